uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, run-time selectable parity and stop-bit count, and a configurable data width. It sits between a bus-side register block, which pushes characters through a valid/ready port, and the serial `tx` pin. It sends frames back to back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Character push port of the UART transmitter: valid/ready handshake from the register block.
interface uart_tx_fifo_if #(
    parameter int unsigned DW = 8
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a transmit FIFO; frames are sent back to back while data is queued.
// Baud divisor, parity mode and stop-bit count are captured at each frame start.
module uart_tx_fifo #(
    parameter int unsigned DW     = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned BAUD_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [BAUD_W-1:0]      baud_div,
    input  logic [1:0]             parity,
    input  logic                   stop2,
    uart_tx_fifo_if.slave          wr,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic                   done,
    output logic                   tx
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q, count_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic [3:0]        bit_q, bit_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic              tx_q, tx_d, done_q, done_d;
    logic              push, pop, launch, tick;

    assign full        = (count_q == FullLevel);
    assign empty       = (count_q == '0);
    assign level       = count_q;
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    assign tick        = (cnt_q == '0);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign tx          = tx_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? div_q : cnt_q - BAUD_W'(1);
        div_d     = div_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        launch    = 1'b0;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: launch = en && !empty;
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_q == 4'(DW - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (bit_q == {3'b000, stop2_q}) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                        launch  = en && !empty;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame start: pop the head and capture this frame's line settings.
        if (launch) begin
            pop       = 1'b1;
            state_d   = StStart;
            tx_d      = 1'b0;
            shift_d   = mem[rptr_q];
            cnt_d     = baud_div;
            div_d     = baud_div;
            par_en_d  = (parity == 2'b01) || (parity == 2'b10);
            par_bit_d = (^mem[rptr_q]) ^ (parity == 2'b10);
            stop2_d   = stop2;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wr.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle line, done and busy traces compared against a frame model.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0]  parity = '0;
    logic        stop2 = 1'b0;
    logic [2:0]  level;
    logic        empty, full, busy, done, tx;
    int          errors = 0;
    int          checks = 0;

    uart_tx_fifo_if #(.DW(8)) wr_if ();

    uart_tx_fifo #(.DW(8), .DEPTH(4), .BAUD_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .baud_div (baud_div),
        .parity   (parity),
        .stop2    (stop2),
        .wr       (wr_if),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .busy     (busy),
        .done     (done),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Expected per-cycle traces for back-to-back frames, sample 0 = cycle after the first start.
    function automatic int model(input logic [7:0] chars[$], input logic [1:0] par,
                                 input logic s2, input int div, output logic [255:0] et,
                                 output logic [255:0] ed, output logic [255:0] eb);
        logic bits[$];
        int   pos = 0;
        et = '1;
        ed = '0;
        eb = '0;
        foreach (chars[c]) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(chars[c][i]);
            if (par == 2'b01) bits.push_back(^chars[c]);
            if (par == 2'b10) bits.push_back(~^chars[c]);
            bits.push_back(1'b1);
            if (s2) bits.push_back(1'b1);
            foreach (bits[b]) begin
                repeat (div + 1) begin
                    et[pos] = bits[b];
                    eb[pos] = 1'b1;
                    pos++;
                end
            end
            ed[pos] = 1'b1;
        end
        return pos;
    endfunction

    task automatic capture(input int n, output logic [255:0] wt, output logic [255:0] wd,
                           output logic [255:0] wb);
        wt = '1;
        wd = '0;
        wb = '0;
        for (int k = 0; k < n; k++) begin
            wt[k] = tx;
            wd[k] = done;
            wb[k] = busy;
            @(negedge clk);
        end
    endtask

    // Called just after a rising edge; returns just after the edge of the last push.
    task automatic push_chars(input logic [7:0] chars[$]);
        wr_if.wr_valid = 1'b1;
        foreach (chars[i]) begin
            wr_if.wr_data = chars[i];
            @(posedge clk);
            #1;
        end
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_if.wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [7:0]   q[$];
        logic [255:0] et, ed, eb, wt, wd, wb;
        int           len;
        @(posedge clk); #1;
        baud_div = 16'd9; parity = 2'b00; stop2 = 1'b0; en = 1'b1;
        q = {8'hA5};
        push_chars(q);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_latency_tx got=%b exp=1", tx); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_push got=%0d exp=1", level); end
        @(negedge clk); @(negedge clk);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_pop got=%0d exp=0", level); end
        len = model(q, 2'b00, 1'b0, 9, et, ed, eb);
        capture(len + 4, wt, wd, wb);
        checks++; if (wt !== et) begin errors++; $display("FAIL single_tx got=%h exp=%h", wt, et); end
        checks++; if (wd !== ed) begin errors++; $display("FAIL single_done got=%h exp=%h", wd, ed); end
        checks++; if (wb !== eb) begin errors++; $display("FAIL single_busy got=%h exp=%h", wb, eb); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]   q[$];
        logic [255:0] et, ed, eb, wt, wd, wb;
        int           len;
        @(posedge clk); #1;
        baud_div = 16'd9; parity = 2'b00; stop2 = 1'b0; en = 1'b1;
        q = {8'hA5, 8'hF0};
        push_chars(q);
        @(negedge clk);
        // Second push coincided with the first pop.
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level got=%0d exp=1", level); end
        len = model(q, 2'b00, 1'b0, 9, et, ed, eb);
        capture(len + 4, wt, wd, wb);
        checks++; if (wt !== et) begin errors++; $display("FAIL b2b_tx got=%h exp=%h", wt, et); end
        checks++; if (wd !== ed) begin errors++; $display("FAIL b2b_done got=%h exp=%h", wd, ed); end
        checks++; if (wb !== eb) begin errors++; $display("FAIL b2b_busy got=%h exp=%h", wb, eb); end
    endtask

    task automatic test_parity_stop();
        logic [1:0]   p_tab[3] = '{2'b01, 2'b10, 2'b10};
        logic         s_tab[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0]   q[$];
        logic [255:0] et, ed, eb, wt, wd, wb;
        int           len;
        q = {8'hF0};
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            baud_div = 16'd9; parity = p_tab[t]; stop2 = s_tab[t]; en = 1'b1;
            push_chars(q);
            @(negedge clk); @(negedge clk);
            len = model(q, p_tab[t], s_tab[t], 9, et, ed, eb);
            capture(len + 4, wt, wd, wb);
            checks++; if (wt !== et) begin errors++; $display("FAIL par%0d_tx got=%h exp=%h", t, wt, et); end
            checks++; if (wd !== ed) begin errors++; $display("FAIL par%0d_done got=%h exp=%h", t, wd, ed); end
            checks++; if (wb !== eb) begin errors++; $display("FAIL par%0d_busy got=%h exp=%h", t, wb, eb); end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0]   q[$];
        logic [255:0] et, ed, eb, wt, wd, wb;
        int           len;
        @(posedge clk); #1;
        baud_div = 16'd1; parity = 2'b00; stop2 = 1'b0; en = 1'b0;
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        push_chars(q);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", wr_if.wr_ready); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h55;
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_drop_level got=%0d exp=4", level); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL full_disabled got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
        end
        en = 1'b1;
        @(negedge clk); @(negedge clk);
        len = model(q, 2'b00, 1'b0, 1, et, ed, eb);
        capture(len + 4, wt, wd, wb);
        checks++; if (wt !== et) begin errors++; $display("FAIL full_tx got=%h exp=%h", wt, et); end
        checks++; if (wd !== ed) begin errors++; $display("FAIL full_done got=%h exp=%h", wd, ed); end
        checks++; if (wb !== eb) begin errors++; $display("FAIL full_busy got=%h exp=%h", wb, eb); end
    endtask

    task automatic test_random();
        logic [7:0]   q[$];
        logic [255:0] et, ed, eb, wt, wd, wb;
        logic [1:0]   p;
        logic         s2;
        int           n, div, len, flen;
        for (int b = 0; b < 12; b++) begin
            n   = $urandom_range(1, 4);
            p   = 2'($urandom);
            s2  = 1'($urandom);
            div = $urandom_range(0, 4);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            @(posedge clk); #1;
            en = 1'b0; baud_div = 16'(div); parity = p; stop2 = s2;
            push_chars(q);
            checks++; if (level !== 3'(n)) begin errors++; $display("FAIL rnd%0d_level got=%0d exp=%0d", b, level, n); end
            en = 1'b1;
            @(negedge clk); @(negedge clk);
            len  = model(q, p, s2, div, et, ed, eb);
            flen = len / n;
            // Settings change once the last frame has started; that frame must not notice.
            fork
                capture(len + 4, wt, wd, wb);
                begin
                    repeat ((n - 1) * flen + 1) @(negedge clk);
                    baud_div = 16'($urandom_range(0, 15));
                    parity   = 2'($urandom);
                    stop2    = 1'($urandom);
                end
            join
            checks++; if (wt !== et) begin errors++; $display("FAIL rnd%0d_tx got=%h exp=%h", b, wt, et); end
            checks++; if (wd !== ed) begin errors++; $display("FAIL rnd%0d_done got=%h exp=%h", b, wd, ed); end
            checks++; if (wb !== eb) begin errors++; $display("FAIL rnd%0d_busy got=%h exp=%h", b, wb, eb); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]   q[$];
        logic [255:0] wt, wd, wb;
        @(posedge clk); #1;
        baud_div = 16'd9; parity = 2'b00; stop2 = 1'b0; en = 1'b1;
        q = {8'hA5, 8'h3C};
        push_chars(q);
        @(negedge clk);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_level_before got=%0d exp=1", level); end
        repeat (45) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_data3 got=%b exp=0", tx); end
        rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx_async got=%b exp=1", tx); end
        checks++; if (level !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_flush got level=%0d empty=%b exp level=0 empty=1", level, empty);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_state got busy=%b done=%b exp 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        capture(60, wt, wd, wb);
        checks++; if (wt !== '1) begin errors++; $display("FAIL mid_idle_tx got=%h", wt); end
        checks++; if (wd !== '0) begin errors++; $display("FAIL mid_no_done got=%h", wd); end
        checks++; if (wb !== '0) begin errors++; $display("FAIL mid_no_busy got=%h", wb); end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_stop();
        test_fifo_full();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
